// File: rtl/d16_pipe_ctrl.sv
// d16_pipe_ctrl -- pipeline sequencing controller for the d16 core.
//
// Purpose: turns the hazard-unit enable, the jump-taken signal and the
// data-memory request/acknowledge handshake into stage register enables,
// flush and bubble controls for the LI/DI/EX/MEM/RE pipeline.
//
// Handshake: dmem_req is raised by this block and held, together with
// dmem_we, until the rising edge on which dmem_ack=1 is sampled. dmem_ack
// is looked at only while waiting (MEMW); at any other time it is ignored.
//
// Ports:
//   sys_clk       in   core clock, rising edge
//   sys_rst       in   synchronous active-high reset
//   hz_en         in   0 = RAW hazard, insert a bubble
//   jmp           in   taken jump resolved in EX
//   ex_mem_op     in   [7:0] opcode held in EX/MEM
//   dmem_ack      in   data memory finished the current request
//   cnt_clr       in   clears the stall counter
//   pc_en, li_di_en, di_ex_en, ex_mem_en, mem_re_en  out  stage load enables
//   li_di_flush   out  load NOP into LI/DI
//   di_ex_bubble  out  load NOP into DI/EX
//   dmem_req      out  registered data-memory request
//   dmem_we       out  registered write qualifier for dmem_req
//   state         out  [1:0] FSM state: RUN=0, MEMW=1, FLUSH=2
//   stall_cnt     out  [15:0] stalled-cycle counter
//
// Build option: define D16_STALL_CNT_EN to get a saturating stall counter;
// without it stall_cnt is tied to 0 and cnt_clr is unused.

module d16_pipe_ctrl (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        hz_en,
    input  logic        jmp,
    input  logic [7:0]  ex_mem_op,
    input  logic        dmem_ack,
    input  logic        cnt_clr,
    output logic        pc_en,
    output logic        li_di_en,
    output logic        di_ex_en,
    output logic        ex_mem_en,
    output logic        mem_re_en,
    output logic        li_di_flush,
    output logic        di_ex_bubble,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [1:0]  state,
    output logic [15:0] stall_cnt
);

    // d16 memory opcodes
    localparam logic [7:0] D16_OP_LOD = 8'h10;
    localparam logic [7:0] D16_OP_LOP = 8'h11;
    localparam logic [7:0] D16_OP_STR = 8'h12;
    localparam logic [7:0] D16_OP_STP = 8'h13;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_MEMW  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic       mem_done_q, mem_done_d;
    logic       req_d, we_d;
    logic       is_mem, is_store;
    // {pc, li_di, di_ex, ex_mem, mem_re}
    logic [4:0] en;

    assign is_store = (ex_mem_op == D16_OP_STR) || (ex_mem_op == D16_OP_STP);
    assign is_mem   = is_store || (ex_mem_op == D16_OP_LOD) || (ex_mem_op == D16_OP_LOP);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= ST_RUN;
            mem_done_q <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_done_q <= mem_done_d;
            dmem_req   <= req_d;
            dmem_we    <= we_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        mem_done_d   = mem_done_q;
        req_d        = dmem_req;
        we_d         = dmem_we;
        en           = 5'b00000;
        li_di_flush  = 1'b0;
        di_ex_bubble = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (is_mem && !mem_done_q) begin
                    // Freeze everything and launch the request.
                    state_d = ST_MEMW;
                    req_d   = 1'b1;
                    we_d    = is_store;
                end else begin
                    // EX/MEM advances in every remaining RUN case, so the
                    // op that was served leaves and the flag must clear.
                    mem_done_d = 1'b0;
                    en         = 5'b11111;
                    if (jmp) begin
                        li_di_flush  = 1'b1;
                        di_ex_bubble = 1'b1;
                        state_d      = ST_FLUSH;
                    end else if (!hz_en) begin
                        en           = 5'b00111;
                        di_ex_bubble = 1'b1;
                    end
                end
            end
            ST_MEMW: begin
                if (dmem_ack) begin
                    state_d    = ST_RUN;
                    req_d      = 1'b0;
                    we_d       = 1'b0;
                    mem_done_d = 1'b1;
                end
            end
            ST_FLUSH: begin
                // Kill the fetch that was issued before the jump resolved.
                en          = 5'b11111;
                li_di_flush = 1'b1;
                state_d     = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (sys_rst) begin
            en           = 5'b00000;
            li_di_flush  = 1'b1;
            di_ex_bubble = 1'b1;
        end
    end

    assign {pc_en, li_di_en, di_ex_en, ex_mem_en, mem_re_en} = en;
    assign state = state_q;

`ifdef D16_STALL_CNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt_q <= 16'h0000;
        end else if (cnt_clr) begin
            cnt_q <= 16'h0000;
        end else if (!pc_en && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign stall_cnt = cnt_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign stall_cnt      = 16'h0000;
`endif

endmodule
